bitwise_logic_pipe: RTL and testbench
=====================================

// Module: bitwise_logic_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit for the 32-bit ALU datapath.
//  Generalises the single-op combinational OR/AND blocks to an 8-op unit.
//  Has configurable width and pipeline depth, a valid/ready handshake on both sides,
//  a global enable (freeze) and registered result flags.
//  Sits between operand dispatch and the ALU result mux.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=1)
//  STAGES  2   pipeline register stages, 1..4; latency in cycles when not stalled
// PORTS
//  clk       in   1      clock, all state on rising edge
//  rst       in   1      reset, asynchronous, active-high
//  i_enable  in   1      1 = pipeline runs; 0 = freeze (no accept, no advance, outputs hold)
//  i_valid   in   1      operand beat present
//  o_ready   out  1      unit can accept a beat this cycle
//  i_op      in   3      operation code (bitwise_op_e)
//  i_1       in   WIDTH  operand A
//  i_2       in   WIDTH  operand B
//  o_valid   out  1      result beat present
//  i_ready   in   1      downstream accepts result this cycle
//  o         out  WIDTH  result
//  o_zero    out  1      result == 0 (meaningful only while o_valid)
//  o_ones    out  1      result == all ones (meaningful only while o_valid)
//  o_busy    out  1      any stage holds a valid beat
// BEHAVIOUR
//  - Op codes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 NOT_A (~i_1), 7 PASS_A (i_1).
//    i_2 is ignored for 6 and 7.
//  - Result and both flags are computed combinationally from i_op/i_1/i_2 at accept time.
//    They are loaded into stage 1; stages 2..STAGES carry them unchanged.
//  - Accept: i_valid & o_ready & i_enable. Result out: o_valid & i_ready & i_enable.
//  - Per stage k: ready_k = ~valid_k | ready_{k+1}; ready_{STAGES+1} = i_ready.
//    o_ready = ready_1 & i_enable (combinational; no combinational path from i_valid).
//  - Stage k loads from stage k-1 when i_enable & ready_k.
//    valid_k <= valid_{k-1}; data is loaded only when the incoming beat is valid.
//  - Latency: beat accepted at edge N appears on o/o_valid after edge N+STAGES-1,
//    i.e. STAGES cycles from i_valid to o_valid, if not stalled.
//    Full throughput: one beat per cycle with i_ready held high.
//  - Backpressure: with i_ready=0 the pipe fills. After STAGES accepts, o_ready=0.
//    No beat is dropped or duplicated. o, o_zero and o_ones stay stable while o_valid & ~i_ready.
//  - Simultaneous accept and drain on a full pipe is legal (bubble-free).
//  - i_enable=0: all registers hold. o_valid, o, o_zero and o_ones keep their values.
//    o_ready=0 and no beat leaves. Resuming continues exactly where it stopped.
//  - Reset (any time, incl. mid-stream): all valid bits 0, all data/flag registers 0.
//    Outputs: o=0, o_zero=0, o_ones=0, o_valid=0, o_busy=0, o_ready=0 while rst is high.
//    o_ready=i_enable on the first cycle after release. In-flight beats are discarded.
//  - o_zero/o_ones are gated with o_valid at the output (0 when ~o_valid).
//  - WIDTH=1: o_zero and o_ones are mutually exclusive and exact.
// STRUCTURE
//  - Package alu_bitwise_pkg holds:
//      typedef enum logic [2:0] bitwise_op_e (the 8 ops above);
//      function bitwise_eval(op, a, b) returning WIDTH-bit result.
//  - Sub-module bitwise_pipe_stage: one valid/data/flag register slot with the ready rule above.
//    The top generates STAGES instances, plus the front-end evaluate and the output flag gating.
// TESTING
//  - Reset: assert rst mid-stream with 2 beats in flight
//      -> o_valid=0, o=0, o_busy=0 immediately;
//      -> after release o_ready=1 and no stale beat emerges.
//  - Ops, WIDTH=32, STAGES=2, i_ready=1:
//      i_1=32'h0000129F, i_2=32'h00000BD2 for op 0..7
//      -> o = 0x00000292, 0x00001BDF, 0x0000194D, 0xFFFFE420,
//             0xFFFFFD6D, 0xFFFFE6B2, 0xFFFFED60, 0x0000129F;
//      -> each result appears 2 cycles after its accept.
//  - Flags: OR of 0xFFFFFFFF with 0 -> o_ones=1, o_zero=0;
//      AND of 0xFFFFFFFF with 0 -> o_zero=1, o_ones=0.
//  - Backpressure: i_ready=0, stream 5 beats -> exactly 2 accepted, then o_ready=0;
//      release i_ready -> all 5 results emerge in order, none lost or repeated.
//  - Enable: drop i_enable for 3 cycles mid-stream
//      -> o/o_valid frozen, o_ready=0, no accept;
//      -> re-enable and the stream completes in order with unchanged values.
//  - Parameter sweep: WIDTH in {1,8,32}, STAGES in {1,4}
//      -> random ops checked against a reference model; latency == STAGES.

Source files
------------

// File: rtl/alu_bitwise_pkg.sv
// Shared types and the bitwise evaluation function for the ALU bitwise pipe.
package alu_bitwise_pkg;

    // Widest operand the evaluation function handles; instances truncate to WIDTH.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NOR    = 3'd3,
        OP_NAND   = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } bitwise_op_e;

    function automatic logic [MAX_WIDTH-1:0] bitwise_eval(
        input bitwise_op_e          op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOR:   r = ~(a | b);
            OP_NAND:  r = ~(a & b);
            OP_XNOR:  r = ~(a ^ b);
            OP_NOT_A: r = ~a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_pipe_stage.sv
// One pipeline slot: valid bit plus payload, advancing when downstream can take it.
module bitwise_pipe_stage #(
    parameter int unsigned DW = 34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_enable,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          ready_c;

    // Slot can load when empty or when its current beat moves on this cycle.
    always_comb begin
        ready_c = ~valid_q | i_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (i_enable && ready_c) begin
            valid_d = i_valid;
            if (i_valid) begin
                data_d = i_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Pipelined 8-op bitwise unit with valid/ready on both sides, freeze enable and result flags.
// WIDTH must not exceed alu_bitwise_pkg::MAX_WIDTH; STAGES is 1..4.
module bitwise_logic_pipe
    import alu_bitwise_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_zero,
    output logic             o_ones,
    output logic             o_busy
);

    // Payload layout: {ones, zero, result}.
    localparam int unsigned DW = WIDTH + 2;

    logic [WIDTH-1:0] res_c;
    logic             zero_c;
    logic             ones_c;
    logic [STAGES:0]  valid_v;
    logic [DW-1:0]    data_v [STAGES+1];
    logic [STAGES:1]  ready_nxt;
    logic             zero_q;
    logic             ones_q;

    always_comb begin
        res_c  = WIDTH'(bitwise_eval(bitwise_op_e'(i_op), MAX_WIDTH'(i_1), MAX_WIDTH'(i_2)));
        zero_c = (res_c == '0);
        ones_c = &res_c;
    end

    assign valid_v[0] = i_valid;
    assign data_v[0]  = {ones_c, zero_c, res_c};

    // Ready seen by stage k is computed from downstream valid bits directly, avoiding a ripple chain.
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        if (k == STAGES) begin : g_last
            assign ready_nxt[k] = i_ready;
        end else begin : g_mid
            assign ready_nxt[k] = i_ready | ~(&valid_v[STAGES:k+1]);
        end

        bitwise_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .i_enable (i_enable),
            .i_valid  (valid_v[k-1]),
            .i_data   (data_v[k-1]),
            .i_ready  (ready_nxt[k]),
            .o_valid  (valid_v[k]),
            .o_data   (data_v[k])
        );
    end

    assign o_ready            = i_enable & ~rst & (~valid_v[1] | ready_nxt[1]);
    assign o_valid            = valid_v[STAGES];
    assign {ones_q, zero_q, o} = data_v[STAGES];
    assign o_zero             = zero_q & o_valid;
    assign o_ones             = ones_q & o_valid;
    assign o_busy             = |valid_v[STAGES:1];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: directed tests on a 32x2 instance plus a random parameter sweep.
module tb_bitwise_logic_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_sw;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fails = 0;
    int unsigned sw_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_eval(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // ---------------- main 32-bit, 2-stage instance ----------------
    logic        m_en, m_iv, m_ordy, m_ov, m_ir, m_zero, m_ones, m_busy;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_o;

    bitwise_logic_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_enable (m_en),
        .i_valid  (m_iv),
        .o_ready  (m_ordy),
        .i_op     (m_op),
        .i_1      (m_a),
        .i_2      (m_b),
        .o_valid  (m_ov),
        .i_ready  (m_ir),
        .o        (m_o),
        .o_zero   (m_zero),
        .o_ones   (m_ones),
        .o_busy   (m_busy)
    );

    logic [31:0] mq_d[$];
    int unsigned mq_e[$];
    logic [33:0] out_log[$];
    int unsigned m_acc_cnt = 0;
    int unsigned m_out_cnt = 0;
    bit          m_chk_lat = 0;
    bit          m_prev_stall = 0;
    logic [31:0] m_prev_o = '0;

    // Monitor: sample half a cycle away from the active edge and score what the next edge does.
    always @(negedge clk) begin
        logic [31:0] e;
        int unsigned ee;
        #1;
        if (rst) begin
            m_prev_stall = 0;
        end else begin
            if (m_prev_stall) begin
                check("hold_valid", 64'(m_ov), 64'd1);
                check("hold_o", 64'(m_o), 64'(m_prev_o));
            end
            if (m_ov && m_ir && m_en) begin
                if (mq_d.size() == 0) begin
                    check("spurious_beat", 64'(m_ov), 64'd0);
                end else begin
                    e  = mq_d.pop_front();
                    ee = mq_e.pop_front();
                    check("m_o", 64'(m_o), 64'(e));
                    check("m_zero", 64'(m_zero), 64'(e == 32'd0));
                    check("m_ones", 64'(m_ones), 64'(e == 32'hFFFF_FFFF));
                    if (m_chk_lat) check("m_latency", 64'(cyc + 1 - ee), 64'd2);
                end
                out_log.push_back({m_ones, m_zero, m_o});
                m_out_cnt++;
            end
            if (m_iv && m_ordy && m_en) begin
                mq_d.push_back(32'(ref_eval(m_op, 64'(m_a), 64'(m_b))));
                mq_e.push_back(cyc + 1);
                m_acc_cnt++;
            end
            m_prev_stall = m_ov && (!m_ir || !m_en);
            m_prev_o     = m_o;
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit got = 0;
        m_iv = 1'b1; m_op = op; m_a = a; m_b = b;
        for (int n = 0; n < 200 && !got; n++) begin
            #1;
            got = m_ordy && m_en;
            @(negedge clk);
        end
        check("send_accept", 64'(got), 64'd1);
    endtask

    task automatic drain();
        bit ok = 0;
        m_iv = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = (mq_d.size() == 0) && !m_busy;
        end
        check("drain", 64'(ok), 64'd1);
        @(negedge clk);
    endtask

    // ---------------- parameter sweep instances ----------------
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned W = (g < 2) ? 1 : (g == 2) ? 8 : 32;
        localparam int unsigned S = (g == 1 || g == 3) ? 4 : 1;
        logic         iv, ordy, ov, ir, zo, on, bz;
        logic [2:0]   op;
        logic [W-1:0] a, b, o;
        logic [W-1:0] eq[$];
        int unsigned  eedge[$];

        bitwise_logic_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk      (clk),
            .rst      (rst_sw),
            .i_enable (1'b1),
            .i_valid  (iv),
            .o_ready  (ordy),
            .i_op     (op),
            .i_1      (a),
            .i_2      (b),
            .o_valid  (ov),
            .i_ready  (ir),
            .o        (o),
            .o_zero   (zo),
            .o_ones   (on),
            .o_busy   (bz)
        );

        initial begin : p_sw
            logic [W-1:0] e;
            int unsigned  ee;
            iv = 1'b0; op = '0; a = '0; b = '0; ir = 1'b1;
            @(negedge clk);
            while (rst_sw) @(negedge clk);
            for (int c = 0; c < 260; c++) begin
                @(negedge clk);
                if (c < 220) begin
                    iv = ($urandom_range(0, 3) != 0);
                    op = 3'($urandom_range(0, 7));
                    a  = W'({$urandom, $urandom});
                    b  = W'({$urandom, $urandom});
                end else begin
                    iv = 1'b0;
                end
                ir = (c < 120 || c >= 220) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                if (ov && ir) begin
                    if (eq.size() == 0) begin
                        check($sformatf("sw%0d_spurious", g), 64'(ov), 64'd0);
                    end else begin
                        e  = eq.pop_front();
                        ee = eedge.pop_front();
                        check($sformatf("sw%0d_o", g), 64'(o), 64'(e));
                        check($sformatf("sw%0d_zero", g), 64'(zo), 64'(e == '0));
                        check($sformatf("sw%0d_ones", g), 64'(on), 64'(&e));
                        if (c < 120) check($sformatf("sw%0d_latency", g), 64'(cyc + 1 - ee), 64'(S));
                    end
                end
                if (iv && ordy) begin
                    eq.push_back(W'(ref_eval(op, 64'(a), 64'(b))));
                    eedge.push_back(cyc + 1);
                end
            end
            check($sformatf("sw%0d_busy_end", g), 64'(bz), 64'd0);
            check($sformatf("sw%0d_left", g), 64'(eq.size()), 64'd0);
            sw_done++;
        end
    end

    // ---------------- directed sequence ----------------
    logic [31:0] op_exp [8] = '{32'h0000_0292, 32'h0000_1BDF, 32'h0000_194D, 32'hFFFF_E420,
                                32'hFFFF_FD6D, 32'hFFFF_E6B2, 32'hFFFF_ED60, 32'h0000_129F};

    initial begin : p_main
        logic [2:0]  bp_op [5];
        logic [31:0] bp_a [5], bp_b [5];
        logic [31:0] f_o;
        logic        f_v;
        int unsigned j, a0, o0;
        bit          sw_ok;

        rst = 1'b1; rst_sw = 1'b1;
        m_en = 1'b1; m_iv = 1'b0; m_ir = 1'b1; m_op = '0; m_a = '0; m_b = '0;
        #1;
        check("rst_valid", 64'(m_ov), 64'd0);
        check("rst_o", 64'(m_o), 64'd0);
        check("rst_busy", 64'(m_busy), 64'd0);
        check("rst_ready", 64'(m_ordy), 64'd0);
        check("rst_zero", 64'(m_zero), 64'd0);
        check("rst_ones", 64'(m_ones), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_sw = 1'b0;
        #1;
        check("rel_ready", 64'(m_ordy), 64'd1);
        @(negedge clk);

        // All eight ops on the reference operands, full throughput.
        m_chk_lat = 1;
        out_log.delete();
        for (int k = 0; k < 8; k++) send(3'(k), 32'h0000_129F, 32'h0000_0BD2);
        drain();
        check("ops_count", 64'(out_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < out_log.size(); k++)
            check($sformatf("op%0d_result", k), 64'(out_log[k][31:0]), 64'(op_exp[k]));

        // Flag extremes.
        out_log.delete();
        send(3'd1, 32'hFFFF_FFFF, 32'h0);
        send(3'd0, 32'hFFFF_FFFF, 32'h0);
        drain();
        check("flag_count", 64'(out_log.size()), 64'd2);
        if (out_log.size() == 2) begin
            check("or_ones", 64'(out_log[0][33]), 64'd1);
            check("or_zero", 64'(out_log[0][32]), 64'd0);
            check("and_zero", 64'(out_log[1][32]), 64'd1);
            check("and_ones", 64'(out_log[1][33]), 64'd0);
        end

        // Backpressure: only STAGES beats fit while the sink is stalled.
        m_chk_lat = 0;
        out_log.delete();
        for (int k = 0; k < 5; k++) begin
            bp_op[k] = 3'($urandom_range(0, 7));
            bp_a[k]  = $urandom;
            bp_b[k]  = $urandom;
        end
        m_ir = 1'b0;
        j = 0;
        for (int c = 0; c < 5; c++) begin
            m_iv = 1'b1; m_op = bp_op[j]; m_a = bp_a[j]; m_b = bp_b[j];
            #1;
            if (m_ordy) j++;
            @(negedge clk);
        end
        #1;
        check("bp_accepted", 64'(j), 64'd2);
        check("bp_ready_low", 64'(m_ordy), 64'd0);
        @(negedge clk);
        m_ir = 1'b1;
        while (j < 5) begin
            send(bp_op[j], bp_a[j], bp_b[j]);
            j++;
        end
        drain();
        check("bp_count", 64'(out_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < out_log.size(); k++)
            check($sformatf("bp_beat%0d", k), 64'(out_log[k][31:0]),
                  ref_eval(bp_op[k], 64'(bp_a[k]), 64'(bp_b[k])) & 64'hFFFF_FFFF);

        // Freeze for three cycles mid-stream.
        out_log.delete();
        for (int k = 0; k < 3; k++) send(3'(k + 2), 32'hA5A5_0F0F + 32'(k), 32'h3C3C_5A5A);
        m_en = 1'b0;
        m_iv = 1'b1; m_op = 3'd5; m_a = 32'h1234_5678; m_b = 32'h0F0F_F0F0;
        #1;
        f_o = m_o; f_v = m_ov; a0 = m_acc_cnt; o0 = m_out_cnt;
        check("fz_inflight", 64'(f_v), 64'd1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            check("fz_ready", 64'(m_ordy), 64'd0);
            check("fz_valid", 64'(m_ov), 64'(f_v));
            check("fz_o", 64'(m_o), 64'(f_o));
        end
        check("fz_no_accept", 64'(m_acc_cnt), 64'(a0));
        check("fz_no_output", 64'(m_out_cnt), 64'(o0));
        @(negedge clk);
        m_en = 1'b1;
        send(3'd5, 32'h1234_5678, 32'h0F0F_F0F0);
        send(3'd6, 32'h8000_0001, 32'h0);
        drain();
        check("fz_count", 64'(out_log.size()), 64'd5);

        // Reset with two beats in flight.
        m_ir = 1'b0;
        send(3'd2, 32'hDEAD_BEEF, 32'h1111_1111);
        send(3'd7, 32'hCAFE_F00D, 32'h0);
        m_iv = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(m_ov), 64'd0);
        check("mid_rst_o", 64'(m_o), 64'd0);
        check("mid_rst_busy", 64'(m_busy), 64'd0);
        check("mid_rst_ready", 64'(m_ordy), 64'd0);
        mq_d.delete(); mq_e.delete();
        @(negedge clk);
        rst = 1'b0;
        m_ir = 1'b1;
        #1;
        check("mid_rel_ready", 64'(m_ordy), 64'd1);
        o0 = m_out_cnt;
        repeat (6) @(negedge clk);
        #1;
        check("no_stale_beat", 64'(m_out_cnt), 64'(o0));
        check("no_stale_busy", 64'(m_busy), 64'd0);

        sw_ok = 0;
        for (int n = 0; n < 2000 && !sw_ok; n++) begin
            @(negedge clk);
            sw_ok = (sw_done == 4);
        end
        check("sweep_done", 64'(sw_done), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
